// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM states, default phase durations, frame size
// and the checksum helper used by both the responder and the initiator.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_DELAY,
    ST_ACK_LOW,
    ST_ACK_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht11_state_e;

  localparam int DHT11_TICKS_PER_US  = 50;
  localparam int DHT11_START_MIN_US  = 18000;
  localparam int DHT11_RESP_DELAY_US = 30;
  localparam int DHT11_ACK_LOW_US    = 80;
  localparam int DHT11_ACK_HIGH_US   = 80;
  localparam int DHT11_BIT_LOW_US    = 50;
  localparam int DHT11_BIT0_HIGH_US  = 26;
  localparam int DHT11_BIT1_HIGH_US  = 70;

  localparam int FRAME_BITS = 40;

  // Checksum is the byte-wise sum of the four payload bytes, modulo 256.
  function automatic logic [7:0] dht11_checksum(
    input logic [7:0] hum_int,
    input logic [7:0] hum_float,
    input logic [7:0] temp_int,
    input logic [7:0] temp_float
  );
    return hum_int + hum_float + temp_int + temp_float;
  endfunction

endpackage

// File: rtl/dht11_line_sync.sv
// Two-flop synchronizer for the single-wire DHT11 line, with one-cycle
// falling/rising edge strobes derived from the synchronized level.
module dht11_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic ln,
  output logic fall,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resample the line and keep the previous synchronized level; an idle bus is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign ln   = sync_q;
  assign fall = prev_q & ~sync_q;
  assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a valid host start pulse, answers with the
// 80/80 us acknowledge and shifts out a 40-bit humidity/temperature frame.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int TICKS_PER_US  = DHT11_TICKS_PER_US,
  parameter int START_MIN_US  = DHT11_START_MIN_US,
  parameter int RESP_DELAY_US = DHT11_RESP_DELAY_US,
  parameter int ACK_LOW_US    = DHT11_ACK_LOW_US,
  parameter int ACK_HIGH_US   = DHT11_ACK_HIGH_US,
  parameter int BIT_LOW_US    = DHT11_BIT_LOW_US,
  parameter int BIT0_HIGH_US  = DHT11_BIT0_HIGH_US,
  parameter int BIT1_HIGH_US  = DHT11_BIT1_HIGH_US
) (
  input  logic       clk_50m,
  input  logic       rst,
  inout  wire        dat_io,
  input  logic       en,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
  input  logic       inject_error,
  output logic       busy,
  output logic       done
);

  localparam int START_TICKS_I = START_MIN_US * TICKS_PER_US;
  localparam int TW = $clog2(START_TICKS_I) + 1;

  // Phase terminal counts: a phase of N ticks runs the timer 0..N-1.
  localparam logic [TW-1:0] START_TICKS    = TW'(START_TICKS_I);
  localparam logic [TW-1:0] RESP_LAST      = TW'(RESP_DELAY_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] ACK_LOW_LAST   = TW'(ACK_LOW_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] ACK_HIGH_LAST  = TW'(ACK_HIGH_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] BIT_LOW_LAST   = TW'(BIT_LOW_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] BIT0_HIGH_LAST = TW'(BIT0_HIGH_US * TICKS_PER_US - 1);
  localparam logic [TW-1:0] BIT1_HIGH_LAST = TW'(BIT1_HIGH_US * TICKS_PER_US - 1);
  localparam logic [5:0]    LAST_BIT_IDX   = 6'(FRAME_BITS - 1);

  dht11_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0] frame_q;
  logic load_frame;
  logic shift_frame;
  logic drive_low;
  logic ln, ln_fall, ln_rise;

  dht11_line_sync u_sync (
    .clk     (clk_50m),
    .rst     (rst),
    .line_in (dat_io),
    .ln      (ln),
    .fall    (ln_fall),
    .rise    (ln_rise)
  );

  // Open-drain output: pull low or release, never drive high.
  assign dat_io = drive_low ? 1'b0 : 1'bz;

  // Next-state, phase timer and bit counter logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    load_frame  = 1'b0;
    shift_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (en && !ln) state_d = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (timer_q >= START_TICKS) timer_d = START_TICKS;
        if (ln_rise) begin
          timer_d = '0;
          state_d = (timer_q >= START_TICKS) ? ST_RESP_DELAY : ST_IDLE;
        end
      end
      ST_RESP_DELAY: begin
        if (ln_fall) begin
          timer_d = '0;
          state_d = ST_HOST_LOW;
        end else if (timer_q == RESP_LAST) begin
          timer_d    = '0;
          load_frame = 1'b1;
          state_d    = ST_ACK_LOW;
        end
      end
      ST_ACK_LOW: begin
        if (timer_q == ACK_LOW_LAST) begin
          timer_d = '0;
          state_d = ST_ACK_HIGH;
        end
      end
      ST_ACK_HIGH: begin
        if (timer_q == ACK_HIGH_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = ST_BIT_LOW;
        end
      end
      ST_BIT_LOW: begin
        if (timer_q == BIT_LOW_LAST) begin
          timer_d = '0;
          state_d = ST_BIT_HIGH;
        end
      end
      ST_BIT_HIGH: begin
        if (timer_q == (frame_q[FRAME_BITS-1] ? BIT1_HIGH_LAST : BIT0_HIGH_LAST)) begin
          timer_d     = '0;
          shift_frame = 1'b1;
          if (bit_idx_q < LAST_BIT_IDX) begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = ST_BIT_LOW;
          end else begin
            state_d = ST_END_LOW;
          end
        end
      end
      ST_END_LOW: begin
        if (timer_q == BIT_LOW_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, timer and bit index registers.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Snapshot payload plus checksum at acknowledge start, then shift MSB-first.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      frame_q <= '0;
    end else if (load_frame) begin
      frame_q <= {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT,
                  dht11_checksum(HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT) ^ {7'd0, inject_error}};
    end else if (shift_frame) begin
      frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Registered line driver and status flags; the driver trails the state by one cycle.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      drive_low <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      drive_low <= (state_q == ST_ACK_LOW) || (state_q == ST_BIT_LOW) || (state_q == ST_END_LOW);
      busy      <= (state_d != ST_IDLE) && (state_d != ST_HOST_LOW);
      done      <= (state_q == ST_END_LOW) && (state_d == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder: emulates the host pulse, records the
// line as run lengths and compares them with a frame model built from payload bytes.
module tb_dht11_responder;

  localparam int T_ACK_LOW  = 80;
  localparam int T_ACK_HIGH = 80;
  localparam int T_BIT_LOW  = 50;
  localparam int T_BIT0     = 26;
  localparam int T_BIT1     = 70;

  logic clk;
  logic rst;
  logic en;
  logic host_low;
  logic [7:0] hum_int, hum_float, temp_int, temp_float;
  logic inject_error;
  logic busy, done;
  wire  dat_line;

  int n_checks;
  int n_fail;

  int seg_len[128];
  int exp_len[85];
  int seg_cnt;
  int done_cnt;
  bit done_bad;
  bit busy_seen;
  bit timed_out;
  bit reset_hit;

  pullup (dat_line);
  assign dat_line = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .TICKS_PER_US (1),
    .START_MIN_US (100)
  ) dut (
    .clk_50m      (clk),
    .rst          (rst),
    .dat_io       (dat_line),
    .en           (en),
    .HUM_INT      (hum_int),
    .HUM_FLOAT    (hum_float),
    .TEMP_INT     (temp_int),
    .TEMP_FLOAT   (temp_float),
    .inject_error (inject_error),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference frame: four bytes then their mod-256 sum with optional LSB flip.
  function automatic logic [39:0] model_frame(input int hi, input int hf, input int ti,
                                              input int tf, input int inj);
    int chk;
    chk = ((hi + hf + ti + tf) % 256) ^ (inj & 1);
    return {hi[7:0], hf[7:0], ti[7:0], tf[7:0], chk[7:0]};
  endfunction

  // Expected run lengths after host release: ack low/high, 40 x (low, 26|70), end low.
  task automatic build_expected(input logic [39:0] f);
    exp_len[0] = 0;
    exp_len[1] = T_ACK_LOW;
    exp_len[2] = T_ACK_HIGH;
    for (int i = 0; i < 40; i++) begin
      exp_len[3 + 2*i] = T_BIT_LOW;
      exp_len[4 + 2*i] = f[39 - i] ? T_BIT1 : T_BIT0;
    end
    exp_len[83] = T_BIT_LOW;
    exp_len[84] = 0;
  endtask

  task automatic host_pulse(input int n);
    @(negedge clk);
    host_low = 1'b1;
    repeat (n) @(negedge clk);
    host_low = 1'b0;
  endtask

  // Record line run lengths, done pulses and busy; optionally alter payload or pulse reset at a segment.
  task automatic capture(input int mutate_seg, input int reset_seg);
    logic prev_lvl;
    int run, cycles, post, done_w;
    bit mutated;
    for (int i = 0; i < 128; i++) seg_len[i] = 0;
    seg_cnt = 0; done_cnt = 0; done_bad = 0; busy_seen = 0; timed_out = 0; reset_hit = 0;
    prev_lvl = 1'b1; run = 0; cycles = 0; post = -1; done_w = 0; mutated = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) busy_seen = 1;
      if (done === 1'b1) done_w++;
      else if (done_w != 0) begin
        done_cnt++;
        if (done_w != 1) done_bad = 1;
        done_w = 0;
      end
      if (dat_line === prev_lvl) run++;
      else begin
        if (seg_cnt < 128) seg_len[seg_cnt] = run;
        seg_cnt++;
        run = 1;
        prev_lvl = dat_line;
      end
      if (seg_cnt == mutate_seg && !mutated) begin
        hum_int = 8'hFF; hum_float = 8'hFF; temp_int = 8'hFF; temp_float = 8'hFF;
        mutated = 1;
      end
      if (seg_cnt == reset_seg) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_hit = 1;
        break;
      end
      if (seg_cnt >= 84 && post < 0) post = 0;
      if (post >= 0) begin
        post++;
        if (post > 20) break;
      end
      if (cycles > 8000) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic set_payload(input int hi, input int hf, input int ti, input int tf, input int inj);
    hum_int = hi[7:0]; hum_float = hf[7:0]; temp_int = ti[7:0]; temp_float = tf[7:0];
    inject_error = inj[0];
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; host_low = 1'b0;
    set_payload(0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    n_checks++; if (dat_line !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_line: got %b expected 1", dat_line); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_frames;
    int hi, hf, ti, tf, inj;
    logic [39:0] exp_frame, decoded;
    for (int k = 0; k < 5; k++) begin
      if (k < 2) begin hi = 'h37; hf = 'h00; ti = 'h19; tf = 'h05; inj = k; end
      else begin
        hi = $urandom_range(0, 255); hf = $urandom_range(0, 255);
        ti = $urandom_range(0, 255); tf = $urandom_range(0, 255); inj = $urandom_range(0, 1);
      end
      set_payload(hi, hf, ti, tf, inj);
      exp_frame = model_frame(hi, hf, ti, tf, inj);
      build_expected(exp_frame);
      host_pulse(120);
      capture(-1, -1);
      decoded = '0;
      for (int i = 0; i < 40; i++) decoded[39 - i] = (seg_len[4 + 2*i] > 48);
      n_checks++; if (timed_out) begin n_fail++; $display("[TB] FAIL frame%0d_timeout: got %0d segments expected 84", k, seg_cnt); end
      n_checks++; if (decoded !== exp_frame) begin n_fail++; $display("[TB] FAIL frame%0d_data: got %h expected %h", k, decoded, exp_frame); end
      for (int i = 1; i < 84; i++) begin
        n_checks++; if (seg_len[i] !== exp_len[i]) begin n_fail++; $display("[TB] FAIL frame%0d_seg%0d: got %0d cycles expected %0d", k, i, seg_len[i], exp_len[i]); end
      end
      n_checks++; if (seg_len[0] < 30 || seg_len[0] > 36) begin n_fail++; $display("[TB] FAIL frame%0d_resp_delay: got %0d expected 30..36", k, seg_len[0]); end
      n_checks++; if (done_cnt !== 1 || done_bad) begin n_fail++; $display("[TB] FAIL frame%0d_done: got %0d pulses (bad width %0d) expected 1", k, done_cnt, done_bad); end
      n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("[TB] FAIL frame%0d_busy_high: got %b expected 1", k, busy_seen); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL frame%0d_busy_end: got %b expected 0", k, busy); end
    end
  endtask

  task automatic test_short_pulse;
    int lows, busys, dones;
    host_pulse(60);
    lows = 0; busys = 0; dones = 0;
    repeat (150) begin
      @(negedge clk);
      if (dat_line !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      if (done !== 1'b0) dones++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("[TB] FAIL short_drive: got %0d low cycles expected 0", lows); end
    n_checks++; if (busys !== 0) begin n_fail++; $display("[TB] FAIL short_busy: got %0d busy cycles expected 0", busys); end
    n_checks++; if (dones !== 0) begin n_fail++; $display("[TB] FAIL short_done: got %0d done cycles expected 0", dones); end
  endtask

  task automatic test_disabled;
    int lows, busys;
    en = 1'b0;
    host_pulse(120);
    lows = 0; busys = 0;
    repeat (300) begin
      @(negedge clk);
      if (dat_line !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("[TB] FAIL disabled_drive: got %0d low cycles expected 0", lows); end
    n_checks++; if (busys !== 0) begin n_fail++; $display("[TB] FAIL disabled_busy: got %0d busy cycles expected 0", busys); end
    en = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_restart_in_delay;
    int lows;
    logic [39:0] exp_frame, decoded;
    set_payload('h12, 'h34, 'h56, 'h78, 0);
    exp_frame = model_frame('h12, 'h34, 'h56, 'h78, 0);
    build_expected(exp_frame);
    host_pulse(120);
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (dat_line !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("[TB] FAIL restart_early_drive: got %0d low cycles expected 0", lows); end
    host_pulse(120);
    capture(-1, -1);
    decoded = '0;
    for (int i = 0; i < 40; i++) decoded[39 - i] = (seg_len[4 + 2*i] > 48);
    n_checks++; if (timed_out) begin n_fail++; $display("[TB] FAIL restart_timeout: got %0d segments expected 84", seg_cnt); end
    n_checks++; if (decoded !== exp_frame) begin n_fail++; $display("[TB] FAIL restart_data: got %h expected %h", decoded, exp_frame); end
    for (int i = 1; i < 84; i++) begin
      n_checks++; if (seg_len[i] !== exp_len[i]) begin n_fail++; $display("[TB] FAIL restart_seg%0d: got %0d cycles expected %0d", i, seg_len[i], exp_len[i]); end
    end
    n_checks++; if (done_cnt !== 1 || done_bad) begin n_fail++; $display("[TB] FAIL restart_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_payload_change;
    logic [39:0] exp_frame, decoded;
    set_payload('h37, 'h00, 'h19, 'h05, 0);
    exp_frame = model_frame('h37, 'h00, 'h19, 'h05, 0);
    build_expected(exp_frame);
    host_pulse(120);
    capture(14, -1);
    decoded = '0;
    for (int i = 0; i < 40; i++) decoded[39 - i] = (seg_len[4 + 2*i] > 48);
    n_checks++; if (timed_out) begin n_fail++; $display("[TB] FAIL hold_timeout: got %0d segments expected 84", seg_cnt); end
    n_checks++; if (decoded !== exp_frame) begin n_fail++; $display("[TB] FAIL hold_data: got %h expected %h", decoded, exp_frame); end
    for (int i = 1; i < 84; i++) begin
      n_checks++; if (seg_len[i] !== exp_len[i]) begin n_fail++; $display("[TB] FAIL hold_seg%0d: got %0d cycles expected %0d", i, seg_len[i], exp_len[i]); end
    end
    n_checks++; if (done_cnt !== 1 || done_bad) begin n_fail++; $display("[TB] FAIL hold_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    int lows, busys, dones;
    logic [39:0] exp_frame, decoded;
    set_payload('hA5, 'h5A, 'h0F, 'hF0, 1);
    exp_frame = model_frame('hA5, 'h5A, 'h0F, 'hF0, 1);
    build_expected(exp_frame);
    host_pulse(120);
    capture(-1, 43);
    n_checks++; if (reset_hit !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_reached: got %b expected 1", reset_hit); end
    n_checks++; if (dat_line !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_line: got %b expected 1", dat_line); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    lows = 0; busys = 0; dones = (done === 1'b1) ? 1 : 0;
    repeat (200) begin
      @(negedge clk);
      if (dat_line !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      if (done !== 1'b0) dones++;
    end
    n_checks++; if (lows !== 0 || busys !== 0 || dones !== 0) begin n_fail++; $display("[TB] FAIL rstmid_quiet: got lows=%0d busy=%0d done=%0d expected all 0", lows, busys, dones); end
    host_pulse(120);
    capture(-1, -1);
    decoded = '0;
    for (int i = 0; i < 40; i++) decoded[39 - i] = (seg_len[4 + 2*i] > 48);
    n_checks++; if (timed_out) begin n_fail++; $display("[TB] FAIL rstmid_timeout: got %0d segments expected 84", seg_cnt); end
    n_checks++; if (decoded !== exp_frame) begin n_fail++; $display("[TB] FAIL rstmid_data: got %h expected %h", decoded, exp_frame); end
    for (int i = 1; i < 84; i++) begin
      n_checks++; if (seg_len[i] !== exp_len[i]) begin n_fail++; $display("[TB] FAIL rstmid_seg%0d: got %0d cycles expected %0d", i, seg_len[i], exp_len[i]); end
    end
    n_checks++; if (done_cnt !== 1 || done_bad) begin n_fail++; $display("[TB] FAIL rstmid_done: got %0d pulses expected 1", done_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    $display("[TB] starting dht11_responder bench");
    test_reset();
    test_frames();
    test_short_pulse();
    test_disabled();
    test_restart_in_delay();
    test_payload_change();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
